// File: rtl/apb_pkg.sv
// Shared types and constants for the APB memory responder.
// Wait-state randomisation is enabled with APB_RAND_WAIT_EN.
package apb_pkg;

  typedef enum logic {
    IDLE,
    ACCESS
  } apb_resp_state_e;

  localparam int          APB_WAIT_CNT_W = 8;
  localparam logic [15:0] LFSR16_TAPS    = 16'hB400;

endpackage

// File: rtl/apb_lfsr16.sv
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1), free-running.
// Only compiled when APB_RAND_WAIT_EN is defined.
`ifdef APB_RAND_WAIT_EN
module apb_lfsr16
  import apb_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] value
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value <= seed;
    end else begin
      value <= (value >> 1) ^ (value[0] ? LFSR16_TAPS : 16'h0000);
    end
  end

endmodule
`endif

// File: rtl/apb_mem_responder.sv
// APB completer: word-addressed flop memory with byte strobes and wait states.
// Define APB_RAND_WAIT_EN to add 0..3 LFSR-driven extra wait states.
module apb_mem_responder
  import apb_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h1000_0000,
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in_paddr,
  input  logic        in_psel,
  input  logic        in_penable,
  input  logic [2:0]  in_pprot,
  input  logic        in_pwrite,
  input  logic [31:0] in_pwdata,
  input  logic [3:0]  in_pstrb,
  output logic        in_pready,
  output logic [31:0] in_prdata,
  output logic        in_pslverr,
  output logic        busy
);

  localparam int          IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN  = 32'(DEPTH_WORDS) << 2;

  typedef logic [APB_WAIT_CNT_W-1:0] cnt_t;

  apb_resp_state_e state, state_d;
  cnt_t            cnt_q, cnt_d;
  cnt_t            wait_ld;

  logic [31:0] addr_q;
  logic        write_q;
  logic [31:0] wdata_q;
  logic [3:0]  strb_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]      off;
  logic [IDX_W-1:0] idx;
  logic             dec_err;
  logic             setup;
  logic             mem_we;

  logic unused_prot;
  assign unused_prot = ^in_pprot;

`ifdef APB_RAND_WAIT_EN
  logic [15:0] lfsr;
  logic        unused_lfsr;

  apb_lfsr16 u_lfsr (
    .clock (clock),
    .reset (reset),
    .seed  (LFSR_SEED),
    .value (lfsr)
  );

  assign wait_ld     = cnt_t'(WAIT_CYCLES) + cnt_t'(lfsr[1:0]);
  assign unused_lfsr = ^lfsr[15:2];
`else
  logic unused_seed;

  assign wait_ld     = cnt_t'(WAIT_CYCLES);
  assign unused_seed = ^LFSR_SEED;
`endif

  // Offset wraps modulo 2^32, so addresses below the base decode as errors.
  assign off     = addr_q - ADDR_BASE;
  assign idx     = off[IDX_W+1:2];
  assign dec_err = (addr_q[1:0] != 2'b00) || (off >= SPAN);
  assign setup   = in_psel && !in_penable;
  assign busy    = (state != IDLE);

  always_comb begin
    state_d    = state;
    cnt_d      = cnt_q;
    in_pready  = 1'b0;
    in_prdata  = 32'h0;
    in_pslverr = 1'b0;
    mem_we     = 1'b0;
    unique case (state)
      IDLE: begin
        if (setup) begin
          state_d = ACCESS;
          cnt_d   = wait_ld;
        end
      end
      ACCESS: begin
        if (!in_psel) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - cnt_t'(1);
        end else begin
          in_pready  = 1'b1;
          in_pslverr = dec_err;
          mem_we     = write_q && !dec_err;
          if (!write_q && !dec_err) begin
            in_prdata = mem[idx];
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else begin
      state <= state_d;
      cnt_q <= cnt_d;
      if (state == IDLE && setup) begin
        addr_q  <= in_paddr;
        write_q <= in_pwrite;
        wdata_q <= in_pwdata;
        strb_q  <= in_pstrb;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (strb_q[i]) begin
          mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

endmodule
